// File: rtl/display_pkg.sv
// Shared constants and state encoding for the display-side SPI receiver.
package display_pkg;

    localparam int         TITLE_BITS  = 128;
    localparam int         NOTE_BITS   = 24;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        DONE
    } rx_state_t;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with registered
// rise/fall strobes and a one-cycle-delayed copy of the synced level.
// The delayed level lines up with the edge strobes, so a data line run
// through an identical instance yields the value present at the edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    // Synchronizer chain, delayed copy and edge strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg  <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
            level_reg <= synced;
            rise_reg  <= synced & ~level_reg;
            fall_reg  <= ~synced & level_reg;
        end
    end

    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign level = level_reg;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: oversamples the MCU's SPI lines on clk, shifts one
// MSB-first frame per spiLoad window and commits it atomically into the
// title or note buffer, then acknowledges with spiDone.
module spi_frame_rx
    import display_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DONE_CYCLES = 400,
    parameter int TITLE_BYTES = TITLE_BITS / 8,
    parameter int NOTE_BYTES  = NOTE_BITS / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck,
    input  logic                     sdi,
    input  logic                     spiLoad,
    input  logic                     titleNote,
    output logic [8*TITLE_BYTES-1:0] title,
    output logic [8*NOTE_BYTES-1:0]  note,
    output logic                     newTitle,
    output logic                     newNote,
    output logic                     frameErr,
    output logic                     spiDone
);

    localparam int         TW        = 8 * TITLE_BYTES;
    localparam int         NW        = 8 * NOTE_BYTES;
    localparam int         HOLD_W    = $clog2(DONE_CYCLES + 1);
    localparam logic [7:0] TITLE_CNT = 8'(TW);
    localparam logic [7:0] NOTE_CNT  = 8'(NW);

    // Lane order: 0 sck, 1 spiLoad, 2 sdi, 3 titleNote.
    logic [3:0] raw_vec;
    logic [3:0] rise_vec;
    logic [3:0] fall_vec;
    logic [3:0] level_vec;

    assign raw_vec = {titleNote, sdi, spiLoad, sck};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (raw_vec[gi]),
            .rise (rise_vec[gi]),
            .fall (fall_vec[gi]),
            .level(level_vec[gi])
        );
    end

    logic sck_rise;
    logic load_rise;
    logic load_fall;
    logic sdi_bit;
    logic tn_level;

    assign sck_rise  = rise_vec[0];
    assign load_rise = rise_vec[1];
    assign load_fall = fall_vec[1];
    assign sdi_bit   = level_vec[2];
    assign tn_level  = level_vec[3];

    // Edges of the data/select lines and delayed levels of the strobe
    // lines have no consumer; they are gathered here and trimmed away.
    logic unused_sync;
    assign unused_sync = &{rise_vec[3:2], fall_vec[3:2], fall_vec[0], level_vec[1:0]};

    rx_state_t         state_reg, state_next;
    logic [TW-1:0]     shift_reg, shift_next;
    logic [7:0]        count_reg, count_next;
    logic              target_reg, target_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [TW-1:0]     title_reg, title_next;
    logic [NW-1:0]     note_reg, note_next;
    logic              new_title_reg, new_title_next;
    logic              new_note_reg, new_note_next;
    logic              frame_err_reg, frame_err_next;

    // State and datapath registers; reset restores blank buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            count_reg     <= '0;
            target_reg    <= 1'b0;
            hold_reg      <= '0;
            title_reg     <= {TITLE_BYTES{ASCII_SPACE}};
            note_reg      <= {NOTE_BYTES{ASCII_SPACE}};
            new_title_reg <= 1'b0;
            new_note_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            target_reg    <= target_next;
            hold_reg      <= hold_next;
            title_reg     <= title_next;
            note_reg      <= note_next;
            new_title_reg <= new_title_next;
            new_note_reg  <= new_note_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic: frame capture, length check, commit and hold.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        count_next     = count_reg;
        target_next    = target_reg;
        hold_next      = hold_reg;
        title_next     = title_reg;
        note_next      = note_reg;
        new_title_next = 1'b0;
        new_note_next  = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load_rise) begin
                    target_next = tn_level;
                    shift_next  = '0;
                    count_next  = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                // A frame end takes priority over a coincident clock edge.
                if (load_fall) begin
                    if (count_reg == (target_reg ? TITLE_CNT : NOTE_CNT)) begin
                        state_next = COMMIT;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end
                end else if (sck_rise) begin
                    shift_next = {shift_reg[TW-2:0], sdi_bit};
                    if (count_reg != 8'hFF) begin
                        count_next = count_reg + 8'd1;
                    end
                end
            end
            COMMIT: begin
                if (target_reg) begin
                    title_next     = shift_reg;
                    new_title_next = 1'b1;
                end else begin
                    note_next     = shift_reg[NW-1:0];
                    new_note_next = 1'b1;
                end
                hold_next  = HOLD_W'(DONE_CYCLES);
                state_next = DONE;
            end
            DONE: begin
                if (load_rise) begin
                    target_next = tn_level;
                    shift_next  = '0;
                    count_next  = '0;
                    state_next  = SHIFT;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                    if (hold_reg <= HOLD_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign title    = title_reg;
    assign note     = note_reg;
    assign newTitle = new_title_reg;
    assign newNote  = new_note_reg;
    assign frameErr = frame_err_reg;
    assign spiDone  = (state_reg == DONE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed frames plus random frames
// compared against a buffer-level model of what each frame should commit.
module tb_spi_frame_rx;
    import display_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         sck;
    logic         sdi;
    logic         spiLoad;
    logic         titleNote;
    logic [127:0] title;
    logic [23:0]  note;
    logic         newTitle;
    logic         newNote;
    logic         frameErr;
    logic         spiDone;

    always #5 clk = ~clk;

    spi_frame_rx dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .spiLoad  (spiLoad),
        .titleNote(titleNote),
        .title    (title),
        .note     (note),
        .newTitle (newTitle),
        .newNote  (newNote),
        .frameErr (frameErr),
        .spiDone  (spiDone)
    );

    localparam logic [127:0] SPACES16 = {16{8'h20}};
    localparam logic [23:0]  SPACES3  = {3{8'h20}};

    int checks = 0;
    int errors = 0;

    // Pulse/ack counters and buffer contents captured at each update pulse.
    int           nt_cnt = 0;
    int           nn_cnt = 0;
    int           fe_cnt = 0;
    int           done_cnt = 0;
    logic [127:0] title_at_pulse = '0;
    logic [23:0]  note_at_pulse = '0;

    // Reference buffers.
    logic [127:0] title_m;
    logic [23:0]  note_m;

    // Observe DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (newTitle === 1'b1) begin
            nt_cnt++;
            title_at_pulse = title;
        end
        if (newNote === 1'b1) begin
            nn_cnt++;
            note_at_pulse = note;
        end
        if (frameErr === 1'b1) fe_cnt++;
        if (spiDone === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic load_rise(input bit tn);
        @(negedge clk);
        titleNote = tn;
        repeat (3) @(negedge clk);
        spiLoad = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Clock out n bits MSB first (sck = clk/10); optional titleNote toggle
    // before bit toggle_at and reset abort before bit abort_at.
    task automatic shift_bits(input logic [255:0] d, input int n, input int toggle_at,
                              input int abort_at);
        for (int j = 0; j < n; j++) begin
            if (j == abort_at) begin
                reset   = 1'b1;
                spiLoad = 1'b0;
                sck     = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (j == toggle_at) titleNote = ~titleNote;
            sdi = d[n-1-j];
            repeat (5) @(negedge clk);
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic load_fall();
        repeat (4) @(negedge clk);
        spiLoad = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_done_low(input string tag);
        int k = 0;
        while (spiDone === 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_drop"}, 128'(spiDone), 128'd0);
    endtask

    // One complete frame, then compare everything against the model.
    task automatic run_frame(input string tag, input bit tn, input int n, input logic [255:0] d,
                             input int toggle_at, input bit skip_rise, input bit wait_idle);
        int nt0 = nt_cnt;
        int nn0 = nn_cnt;
        int fe0 = fe_cnt;
        int dn0 = done_cnt;
        bit ok  = (n == (tn ? 128 : 24));
        if (!skip_rise) load_rise(tn);
        shift_bits(d, n, toggle_at, -1);
        load_fall();
        if (ok) begin
            if (tn) title_m = d[127:0];
            else note_m = d[23:0];
        end
        chk({tag, "_title"}, title, title_m);
        chk({tag, "_note"}, 128'(note), 128'(note_m));
        chk({tag, "_newTitle_cnt"}, 128'(nt_cnt - nt0), 128'(ok && tn));
        chk({tag, "_newNote_cnt"}, 128'(nn_cnt - nn0), 128'(ok && !tn));
        chk({tag, "_frameErr_cnt"}, 128'(fe_cnt - fe0), 128'(!ok));
        chk({tag, "_spiDone"}, 128'(spiDone), 128'(ok));
        if (ok && tn) chk({tag, "_title_at_pulse"}, title_at_pulse, title_m);
        if (ok && !tn) chk({tag, "_note_at_pulse"}, 128'(note_at_pulse), 128'(note_m));
        if (!ok) chk({tag, "_no_done"}, 128'(done_cnt - dn0), 128'd0);
        if (ok && wait_idle) wait_done_low(tag);
    endtask

    initial begin
        logic [127:0] hcb;
        logic [255:0] d;
        int           dn0;
        int           fe0;
        int           k;

        reset = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        spiLoad = 1'b0;
        titleNote = 1'b0;
        title_m = SPACES16;
        note_m = SPACES3;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_title", title, SPACES16);
        chk("rst_note", 128'(note), 128'(SPACES3));
        chk("rst_flags", 128'({newTitle, newNote, frameErr, spiDone}), 128'd0);
        chk("rst_state", 128'(dut.state_reg), 128'(IDLE));

        // Title frame with full spiDone hold.
        hcb = "Hot Cross Buns  ";
        d = {128'd0, hcb};
        dn0 = done_cnt;
        run_frame("hcb", 1'b1, 128, d, -1, 1'b0, 1'b1);
        chk("hcb_done_cycles", 128'(done_cnt - dn0), 128'd400);

        // Note frame "C#4".
        d = {232'd0, 24'h432334};
        run_frame("c4", 1'b0, 24, d, -1, 1'b0, 1'b1);
        chk("c4_note_literal", 128'(note), 128'h432334);

        // Short and long note frames.
        run_frame("short", 1'b0, 23, rnd256(), -1, 1'b0, 1'b1);
        run_frame("long", 1'b0, 25, rnd256(), -1, 1'b0, 1'b1);

        // Reset after 60 title bits.
        fe0 = fe_cnt;
        load_rise(1'b1);
        shift_bits(rnd256(), 128, -1, 60);
        repeat (10) @(negedge clk);
        title_m = SPACES16;
        note_m = SPACES3;
        chk("abort_title", title, SPACES16);
        chk("abort_note", 128'(note), 128'(SPACES3));
        chk("abort_state", 128'(dut.state_reg), 128'(IDLE));
        chk("abort_no_err", 128'(fe_cnt - fe0), 128'd0);
        chk("abort_spiDone", 128'(spiDone), 128'd0);
        run_frame("after_abort", 1'b1, 128, rnd256(), -1, 1'b0, 1'b1);

        // Reload during DONE.
        run_frame("pre_reload", 1'b1, 128, rnd256(), -1, 1'b0, 1'b0);
        repeat (42) @(negedge clk);
        chk("reload_done_high", 128'(spiDone), 128'd1);
        titleNote = 1'b0;
        spiLoad = 1'b1;
        k = 0;
        while (spiDone === 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("reload_done_fall", 128'(spiDone), 128'd0);
        repeat (6) @(negedge clk);
        run_frame("reload_note", 1'b0, 24, rnd256(), -1, 1'b1, 1'b1);

        // titleNote toggled mid-frame stays a title frame.
        run_frame("toggle", 1'b1, 128, rnd256(), 64, 1'b0, 1'b1);

        // Random frames: random target, length exact or off by one.
        for (int i = 0; i < 6; i++) begin
            bit tn;
            int n;
            int sel;
            tn = 1'($urandom_range(0, 1));
            n = tn ? 128 : 24;
            sel = $urandom_range(0, 3);
            if (sel == 0) n = n - 1;
            else if (sel == 1) n = n + 1;
            run_frame($sformatf("rnd%0d", i), tn, n, rnd256(), -1, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
